div_pipelined_param: RTL and testbench

- Parametrised, fully pipelined restoring integer divider. Successor to the fixed-width 128-bit / 10-stage divider.
- Adds:
  - generic width and quotient-bits-per-stage;
  - per-transaction signed/unsigned mode;
  - remainder output;
  - signed-overflow detection;
  - tag passthrough;
  - valid/ready backpressure.
- Sits between the arithmetic issue logic and the result writeback queue.
- Accepts one operation per cycle when not stalled.

---
 rtl/div_pipelined_param.sv | 139 +++++++++++++
 tb/tb_div_pipelined_param.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_pipelined_param.sv
// Fully pipelined restoring integer divider with signed/unsigned mode, remainder,
// divide-by-zero and signed-overflow flags, tag passthrough and valid/ready backpressure.
module div_pipelined_param #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N = WIDTH / BITS_PER_STAGE;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // The whole pipe moves as one (adv); in_ready never depends on in_valid.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [N:0]       s_valid, s_qneg, s_rneg, s_dbz, s_ovf;
  logic [WIDTH:0]   s_rem [N+1];
  logic [WIDTH-1:0] s_num [N+1];
  logic [WIDTH-1:0] s_den [N+1];
  logic [TAG_W-1:0] s_tag [N+1];

  logic [WIDTH:0]   rem_nx [1:N];
  logic [WIDTH-1:0] num_nx [1:N];

  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  assign abs_dvd = (in_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_dvs = (in_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // s_num starts as the dividend magnitude and shifts left one bit per step;
  // resolved quotient bits fill in from the bottom, so it ends as the quotient.
  always_comb begin
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    for (int g = 1; g <= N; g++) begin
      r = s_rem[g-1];
      q = s_num[g-1];
      for (int b = 0; b < BITS_PER_STAGE; b++) begin
        r = {r[WIDTH-1:0], q[WIDTH-1]};
        q = {q[WIDTH-2:0], 1'b0};
        if (r >= {1'b0, s_den[g-1]}) begin
          r    = r - {1'b0, s_den[g-1]};
          q[0] = 1'b1;
        end
      end
      rem_nx[g] = r;
      num_nx[g] = q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid <= '0;
      s_qneg  <= '0;
      s_rneg  <= '0;
      s_dbz   <= '0;
      s_ovf   <= '0;
      for (int g = 0; g <= N; g++) begin
        s_rem[g] <= '0;
        s_num[g] <= '0;
        s_den[g] <= '0;
        s_tag[g] <= '0;
      end
    end else if (adv) begin
      s_valid[0] <= in_valid;
      s_rem[0]   <= '0;
      s_num[0]   <= abs_dvd;
      s_den[0]   <= abs_dvs;
      s_qneg[0]  <= in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      s_rneg[0]  <= in_signed & dividend[WIDTH-1];
      s_dbz[0]   <= (divisor == '0);
      s_ovf[0]   <= in_signed & (dividend == MIN_VAL) & (divisor == '1);
      s_tag[0]   <= in_tag;
      for (int g = 1; g <= N; g++) begin
        s_valid[g] <= s_valid[g-1];
        s_rem[g]   <= rem_nx[g];
        s_num[g]   <= num_nx[g];
        s_den[g]   <= s_den[g-1];
        s_qneg[g]  <= s_qneg[g-1];
        s_rneg[g]  <= s_rneg[g-1];
        s_dbz[g]   <= s_dbz[g-1];
        s_ovf[g]   <= s_ovf[g-1];
        s_tag[g]   <= s_tag[g-1];
      end
    end
  end

  // With a zero divisor every step subtracts nothing, so the partial remainder
  // ends as |dividend|; re-applying the dividend sign restores the original value.
  logic [WIDTH-1:0] q_fin, r_fin;
  always_comb begin
    q_fin = s_qneg[N] ? -s_num[N] : s_num[N];
    r_fin = s_rneg[N] ? -s_rem[N][WIDTH-1:0] : s_rem[N][WIDTH-1:0];
    if (s_dbz[N]) begin
      q_fin = '1;
    end else if (s_ovf[N]) begin
      q_fin = MIN_VAL;
      r_fin = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      out_tag     <= '0;
    end else if (adv) begin
      out_valid <= s_valid[N];
      if (s_valid[N]) begin
        quotient    <= q_fin;
        remainder   <= r_fin;
        div_by_zero <= s_dbz[N];
        overflow    <= s_ovf[N];
        out_tag     <= s_tag[N];
      end
    end
  end

endmodule

// File: tb/tb_div_pipelined_param.sv
// Bench for div_pipelined_param: directed vectors, back-to-back signed ops, random
// backpressure stream, mid-flight reset, and 8-bit / 64-bit parameter sweeps.
module tb_div_pipelined_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance (32-bit, 1 bit per stage)
  logic        in_valid, in_ready, in_signed, out_valid, out_ready, div_by_zero, overflow;
  logic [31:0] dividend, divisor, quotient, remainder;
  logic [3:0]  in_tag, out_tag;
  logic [69:0] res32;
  assign res32 = {out_tag, div_by_zero, overflow, quotient, remainder};

  div_pipelined_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .dividend(dividend), .divisor(divisor), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow), .out_tag(out_tag)
  );

  // 8-bit, 2 bits per stage
  logic       w8_in_valid, w8_in_ready, w8_in_signed, w8_out_valid, w8_out_ready, w8_dbz, w8_ovf;
  logic [7:0] w8_dividend, w8_divisor, w8_quotient, w8_remainder;
  logic [3:0] w8_in_tag, w8_out_tag;
  logic [21:0] res8;
  assign res8 = {w8_out_tag, w8_dbz, w8_ovf, w8_quotient, w8_remainder};

  div_pipelined_param #(.WIDTH(8), .BITS_PER_STAGE(2), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(w8_in_valid), .in_ready(w8_in_ready), .in_signed(w8_in_signed),
    .dividend(w8_dividend), .divisor(w8_divisor), .in_tag(w8_in_tag), .out_valid(w8_out_valid),
    .out_ready(w8_out_ready), .quotient(w8_quotient), .remainder(w8_remainder),
    .div_by_zero(w8_dbz), .overflow(w8_ovf), .out_tag(w8_out_tag)
  );

  // 64-bit, 4 bits per stage
  logic        w64_in_valid, w64_in_ready, w64_in_signed, w64_out_valid, w64_out_ready, w64_dbz, w64_ovf;
  logic [63:0] w64_dividend, w64_divisor, w64_quotient, w64_remainder;
  logic [3:0]  w64_in_tag, w64_out_tag;
  logic [133:0] res64;
  assign res64 = {w64_out_tag, w64_dbz, w64_ovf, w64_quotient, w64_remainder};

  div_pipelined_param #(.WIDTH(64), .BITS_PER_STAGE(4), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w64_in_valid), .in_ready(w64_in_ready), .in_signed(w64_in_signed),
    .dividend(w64_dividend), .divisor(w64_divisor), .in_tag(w64_in_tag), .out_valid(w64_out_valid),
    .out_ready(w64_out_ready), .quotient(w64_quotient), .remainder(w64_remainder),
    .div_by_zero(w64_dbz), .overflow(w64_ovf), .out_tag(w64_out_tag)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [69:0]  exp_q[$];
  logic [21:0]  exp8_q[$];
  logic [133:0] exp64_q[$];
  int           st8_q[$];
  int           st64_q[$];

  typedef struct {
    logic [31:0] a, b;
    bit          s;
    logic [3:0]  tag;
    logic [31:0] q, r;
    bit          dz, ov;
  } vec_t;
  vec_t vecs[12];

  function automatic void check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input bit s, input logic [3:0] tag,
                              input logic [31:0] q, input logic [31:0] r, input bit dz, input bit ov);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.tag = tag; v.q = q; v.r = r; v.dz = dz; v.ov = ov;
    return v;
  endfunction

  // Reference: plain integer division (truncating toward zero) on w-bit operands.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b, input bit s,
                                output logic [63:0] q, output logic [63:0] r, output bit dz, output bit ov);
    logic [63:0] mask, minv;
    longint sa, sb;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    minv = 64'd1 << (w - 1);
    dz = 1'b0;
    ov = 1'b0;
    if (b == 64'd0) begin
      q = mask; r = a; dz = 1'b1;
    end else if (s && a == minv && b == mask) begin
      q = minv; r = 64'd0; ov = 1'b1;
    end else if (s) begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      q = 64'(sa / sb) & mask;
      r = 64'(sa % sb) & mask;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic logic [69:0] exp32(input logic [31:0] a, input logic [31:0] b, input bit s, input logic [3:0] t);
    logic [63:0] q, r;
    bit dz, ov;
    model(32, {32'd0, a}, {32'd0, b}, s, q, r, dz, ov);
    return {t, dz, ov, q[31:0], r[31:0]};
  endfunction

  task automatic drive(input vec_t v);
    in_valid = 1'b1; dividend = v.a; divisor = v.b; in_signed = v.s; in_tag = v.tag;
  endtask

  task automatic run_single(input vec_t v);
    int k;
    @(negedge clk);
    drive(v);
    check("single_in_ready", in_ready, 1);
    k = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      k++;
    end while (!out_valid && k < 100);
    check("single_latency", k, 34);
    check("single_result", res32, {v.tag, v.dz, v.ov, v.q, v.r});
  endtask

  initial begin
    int t, quiet, n_acc, n_got, cyc;
    bit hold, acc;
    logic [69:0] held;
    logic [31:0] ca, cb;
    bit cs;

    in_valid = 0; in_signed = 0; dividend = '0; divisor = '0; in_tag = '0; out_ready = 1;
    w8_in_valid = 0; w8_in_signed = 0; w8_dividend = '0; w8_divisor = '0; w8_in_tag = '0; w8_out_ready = 1;
    w64_in_valid = 0; w64_in_signed = 0; w64_dividend = '0; w64_divisor = '0; w64_in_tag = '0; w64_out_ready = 1;

    vecs[0]  = mk(32'd100,       32'd7,         0, 4'd3,  32'd14,        32'd2,         0, 0);
    vecs[1]  = mk(32'hFFFFFFF9,  32'd2,         1, 4'd1,  32'hFFFFFFFD,  32'hFFFFFFFF,  0, 0);
    vecs[2]  = mk(32'd7,         32'hFFFFFFFE,  1, 4'd2,  32'hFFFFFFFD,  32'd1,         0, 0);
    vecs[3]  = mk(32'hFFFFFFF9,  32'hFFFFFFFE,  1, 4'd4,  32'd3,         32'hFFFFFFFF,  0, 0);
    vecs[4]  = mk(32'd5,         32'd0,         0, 4'd5,  32'hFFFFFFFF,  32'd5,         1, 0);
    vecs[5]  = mk(32'h80000000,  32'hFFFFFFFF,  1, 4'd6,  32'h80000000,  32'd0,         0, 1);
    vecs[6]  = mk(32'h80000000,  32'hFFFFFFFF,  0, 4'd7,  32'd0,         32'h80000000,  0, 0);
    vecs[7]  = mk(32'hFFFFFFFB,  32'd0,         1, 4'd8,  32'hFFFFFFFF,  32'hFFFFFFFB,  1, 0);
    vecs[8]  = mk(32'hFFFFFFFF,  32'd1,         0, 4'd9,  32'hFFFFFFFF,  32'd0,         0, 0);
    vecs[9]  = mk(32'h80000000,  32'd1,         1, 4'hA,  32'h80000000,  32'd0,         0, 0);
    vecs[10] = mk(32'd3,         32'd10,        1, 4'hB,  32'd0,         32'd3,         0, 0);
    vecs[11] = mk(32'hFFFFFFF9,  32'd2,         0, 4'hC,  32'h7FFFFFFC,  32'd1,         0, 0);

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", res32, 0);
    check("rst_w8_valid", w8_out_valid, 0);
    check("rst_w64_valid", w64_out_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, one at a time
    for (int i = 0; i < 12; i++) run_single(vecs[i]);

    // Three signed ops back to back
    @(negedge clk); drive(vecs[1]);
    @(negedge clk); drive(vecs[2]);
    @(negedge clk); drive(vecs[3]);
    @(negedge clk); in_valid = 1'b0;
    t = 3;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("b2b_latency", t, 34);
    for (int j = 1; j <= 3; j++) begin
      check("b2b_valid", out_valid, 1);
      check("b2b_result", res32, {vecs[j].tag, vecs[j].dz, vecs[j].ov, vecs[j].q, vecs[j].r});
      @(negedge clk);
    end

    // Random stream with random backpressure
    n_acc = 0; n_got = 0; cyc = 0; hold = 0; acc = 0; held = '0;
    while ((n_acc < 40 || exp_q.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (hold) check("hold_stable", {out_valid, res32}, {1'b1, held});
      if (acc) in_valid = 1'b0;
      out_ready = ($urandom_range(0, 99) < 55);
      if (!in_valid && n_acc < 40 && $urandom_range(0, 3) != 0) begin
        ca = $urandom;
        cs = $urandom_range(0, 1);
        case ($urandom_range(0, 9))
          0: cb = 32'd0;
          1: begin ca = 32'h80000000; cb = 32'hFFFFFFFF; end
          2, 3: cb = 32'($urandom_range(1, 1000));
          4: cb = -32'($urandom_range(1, 1000));
          default: cb = $urandom;
        endcase
        in_valid = 1'b1; dividend = ca; divisor = cb; in_signed = cs; in_tag = 4'(n_acc);
      end
      #1;
      check("in_ready_adv", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stream_spurious", 1, 0);
        else check("stream_result", res32, exp_q.pop_front());
        n_got++;
      end
      hold = out_valid && !out_ready;
      held = res32;
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(exp32(dividend, divisor, in_signed, in_tag));
        n_acc++;
      end
    end
    check("stream_timeout", cyc < 3000, 1);
    check("stream_count", n_got, 40);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;

    // Reset while ten ops are in flight
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c <= 10) begin
        in_valid = 1'b1; dividend = $urandom; divisor = 32'($urandom_range(1, 99));
        in_signed = $urandom_range(0, 1); in_tag = 4'(c);
      end else begin
        in_valid = 1'b0;
      end
    end
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outputs", res32, 0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) quiet++;
    end
    check("post_reset_quiet", quiet, 0);

    // Parameter sweep: 8-bit/2 (latency 6) and 64-bit/4 (latency 18), out_ready held high
    for (int c = 0; c < 430; c++) begin
      logic [7:0]  a8, b8;
      logic [63:0] a64, b64, q, r;
      bit s8, s64, dz, ov;
      @(negedge clk);
      if (w8_out_valid) begin
        if (exp8_q.size() == 0) check("w8_spurious", 1, 0);
        else begin
          check("w8_result", res8, exp8_q.pop_front());
          check("w8_latency", c - st8_q.pop_front(), 6);
        end
      end
      if (w64_out_valid) begin
        if (exp64_q.size() == 0) check("w64_spurious", 1, 0);
        else begin
          check("w64_result", res64, exp64_q.pop_front());
          check("w64_latency", c - st64_q.pop_front(), 18);
        end
      end
      if (c < 400) begin
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = $urandom_range(0, 1);
        if (c % 29 == 0) begin a8 = 8'h80; b8 = 8'hFF; end
        if (c % 31 == 0) b8 = 8'h00;
        a64 = {$urandom, $urandom}; s64 = $urandom_range(0, 1);
        case (c % 4)
          0: b64 = 64'($urandom_range(1, 255));
          1: b64 = {32'd0, $urandom};
          2: b64 = -64'($urandom_range(1, 99));
          default: b64 = {$urandom, $urandom};
        endcase
        if (c % 37 == 0) begin a64 = 64'h8000000000000000; b64 = '1; end
        if (c % 41 == 0) b64 = 64'd0;
        w8_in_valid = 1'b1; w8_dividend = a8; w8_divisor = b8; w8_in_signed = s8; w8_in_tag = 4'(c);
        w64_in_valid = 1'b1; w64_dividend = a64; w64_divisor = b64; w64_in_signed = s64; w64_in_tag = 4'(c);
        #1;
        check("w8_in_ready", w8_in_ready, 1);
        check("w64_in_ready", w64_in_ready, 1);
        model(8, {56'd0, a8}, {56'd0, b8}, s8, q, r, dz, ov);
        exp8_q.push_back({4'(c), dz, ov, q[7:0], r[7:0]});
        st8_q.push_back(c);
        model(64, a64, b64, s64, q, r, dz, ov);
        exp64_q.push_back({4'(c), dz, ov, q, r});
        st64_q.push_back(c);
      end else begin
        w8_in_valid = 1'b0;
        w64_in_valid = 1'b0;
      end
    end
    check("w8_drained", exp8_q.size(), 0);
    check("w64_drained", exp64_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
